// File: rtl/oled_spi_byte_tx_if.sv
// oled_spi_byte_tx_if: valid/ready port carrying {dc, byte} words from the init sequencer to the SPI transmitter
//   in_valid  upstream word valid
//   in_ready  transmitter FIFO can accept
//   in_data   byte to send, MSB first
//   in_dc     0 = command, 1 = data
interface oled_spi_byte_tx_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_dc;
   modport master (output in_valid, in_data, in_dc, input in_ready);
   modport slave (input in_valid, in_data, in_dc, output in_ready);
endinterface

// File: rtl/oled_spi_byte_tx.sv
// oled_spi_byte_tx: FIFO-buffered byte transmitter driving the Pmod OLED SPI pins in mode 3, MSB first
//   clk, rst    system clock, synchronous active-high reset
//   in_if       valid/ready {dc, byte} input port (slave side)
//   busy        FSM active or words queued
//   fifo_level  number of queued words
//   spi_cs      chip select, active-low, held low across back-to-back bytes
//   spi_sclk    serial clock, idles high
//   spi_sdin    serial data, changes on SCLK fall
//   spi_dc      D/C# of the byte in flight
module oled_spi_byte_tx #(
   parameter int CLK_DIV    = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int LVL_W      = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   oled_spi_byte_tx_if.slave    in_if,
   output logic                 busy,
   output logic [LVL_W-1:0]     fifo_level,
   output logic                 spi_cs,
   output logic                 spi_sclk,
   output logic                 spi_sdin,
   output logic                 spi_dc
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, DESEL} state_t;
   state_t           state_q, state_d;
   logic [8:0]       mem_q [FIFO_DEPTH];
   logic [8:0]       mem_d [FIFO_DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [LVL_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    div_q, div_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       sh_q, sh_d;
   logic             cs_q, cs_d, sclk_q, sclk_d, sdin_q, sdin_d, dc_q, dc_d;
   logic             push, pop, empty, div_end;
   logic [8:0]       head;

   assign empty          = cnt_q == '0;
   // full blocks a push even if the FSM pops on the same edge
   assign in_if.in_ready = !rst && cnt_q != LVL_W'(FIFO_DEPTH);
   assign push           = in_if.in_valid && in_if.in_ready;
   assign head           = mem_q[rd_q];
   assign div_end        = div_q == DW'(CLK_DIV - 1);
   assign busy           = state_q != IDLE || !empty;
   assign fifo_level     = cnt_q;
   assign spi_cs         = cs_q;
   assign spi_sclk       = sclk_q;
   assign spi_sdin       = sdin_q;
   assign spi_dc         = dc_q;

   always_comb begin
      mem_d   = mem_q;
      state_d = state_q;
      div_d   = div_q + 1'b1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      cs_d    = cs_q;
      sclk_d  = sclk_q;
      sdin_d  = sdin_q;
      dc_d    = dc_q;
      pop     = 1'b0;
      if (push) mem_d[wr_q] = {in_if.in_dc, in_if.in_data};
      case (state_q)
         IDLE: begin
            div_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               sh_d    = head[7:0];
               bit_d   = 3'd7;
               dc_d    = head[8];
               sdin_d  = head[7];
               cs_d    = 1'b0;
               state_d = SETUP;
            end
         end
         SETUP: if (div_end) begin
            div_d   = '0;
            sclk_d  = 1'b0;
            state_d = SHIFT_LO;
         end
         SHIFT_LO: if (div_end) begin
            div_d   = '0;
            sclk_d  = 1'b1;
            state_d = SHIFT_HI;
         end
         SHIFT_HI: if (div_end) begin
            div_d = '0;
            if (bit_q != '0) begin
               bit_d   = bit_q - 1'b1;
               sh_d    = {sh_q[6:0], 1'b0};
               sdin_d  = sh_q[6];
               sclk_d  = 1'b0;
               state_d = SHIFT_LO;
            end else if (!empty) begin
               // chain the next word without releasing CS; SCLK stays high through its SETUP
               pop     = 1'b1;
               sh_d    = head[7:0];
               bit_d   = 3'd7;
               dc_d    = head[8];
               sdin_d  = head[7];
               state_d = SETUP;
            end else begin
               cs_d    = 1'b1;
               state_d = DESEL;
            end
         end
         DESEL: if (div_end) begin
            div_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      wr_d  = wr_q + PW'(push);
      rd_d  = rd_q + PW'(pop);
      cnt_d = cnt_q + LVL_W'(push) - LVL_W'(pop);
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         state_q <= IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         cs_q    <= 1'b1;
         sclk_q  <= 1'b1;
         sdin_q  <= 1'b0;
         dc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         cs_q    <= cs_d;
         sclk_q  <= sclk_d;
         sdin_q  <= sdin_d;
         dc_q    <= dc_d;
      end
   end
endmodule

// File: tb/tb_oled_spi_byte_tx.sv
// tb_oled_spi_byte_tx: directed bench for oled_spi_byte_tx at CLK_DIV=2 (dut 0) and CLK_DIV=1 (dut 1)
module tb_oled_spi_byte_tx;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] cs, sclk, sdin, dc, busy;
   logic [2:0] lvl0, lvl1;
   int         total = 0, bad = 0;

   oled_spi_byte_tx_if bus0 ();
   oled_spi_byte_tx_if bus1 ();

   oled_spi_byte_tx #(.CLK_DIV(2), .FIFO_DEPTH(4), .LVL_W(3)) dut0 (
      .clk(clk), .rst(rst), .in_if(bus0.slave), .busy(busy[0]), .fifo_level(lvl0),
      .spi_cs(cs[0]), .spi_sclk(sclk[0]), .spi_sdin(sdin[0]), .spi_dc(dc[0]));
   oled_spi_byte_tx #(.CLK_DIV(1), .FIFO_DEPTH(4), .LVL_W(3)) dut1 (
      .clk(clk), .rst(rst), .in_if(bus1.slave), .busy(busy[1]), .fifo_level(lvl1),
      .spi_cs(cs[1]), .spi_sclk(sclk[1]), .spi_sdin(sdin[1]), .spi_dc(dc[1]));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required end before 50000 cycles");
      $fatal(1, "watchdog");
   end

   // pin monitor: rebuilds bytes from SCLK rises and checks setup, DC and CS-high timing
   int         dv[2] = '{2, 1};
   int         stab[2], rises[2], bitc[2], cslow[2], cshi[2], last_len[2], nlen[2];
   logic [7:0] sh[2];
   logic [1:0] p_sclk = 2'b11, p_sdin = 2'b00, p_dc = 2'b00, p_cs = 2'b11;
   logic [8:0] rx0[$], rx1[$];

   initial for (int m = 0; m < 2; m++) begin
      stab[m] = 0; rises[m] = 0; bitc[m] = 0; cslow[m] = 0;
      cshi[m] = 100; last_len[m] = 0; nlen[m] = 0; sh[m] = '0;
   end

   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            bitc[m] = 0;
            cslow[m] = 0;
            stab[m] = 0;
         end else begin
            stab[m] = (sdin[m] == p_sdin[m]) ? stab[m] + 1 : 0;
            if (sclk[m] && !p_sclk[m]) begin
               total++;
               if (cs[m] || stab[m] < dv[m]) begin
                  bad++;
                  $display("FAIL rise_setup dut%0d: cs=%0b sdin_stable=%0d, required cs=0 stable>=%0d",
                           m, cs[m], stab[m], dv[m]);
               end
               rises[m]++;
               sh[m] = {sh[m][6:0], sdin[m]};
               bitc[m]++;
               if (bitc[m] == 8) begin
                  if (m == 0) rx0.push_back({dc[m], sh[m]});
                  else rx1.push_back({dc[m], sh[m]});
                  bitc[m] = 0;
               end
            end
            if (dc[m] != p_dc[m]) begin
               total++;
               if (!(sclk[m] && p_sclk[m])) begin
                  bad++;
                  $display("FAIL dc_change dut%0d: sclk prev=%0b now=%0b, required both 1", m, p_sclk[m], sclk[m]);
               end
            end
            if (!cs[m] && p_cs[m]) begin
               total++;
               if (cshi[m] < dv[m]) begin
                  bad++;
                  $display("FAIL cs_high_time dut%0d: got %0d cycles, required >=%0d", m, cshi[m], dv[m]);
               end
            end
            if (cs[m] && !p_cs[m]) begin
               last_len[m] = cslow[m];
               nlen[m]++;
               bitc[m] = 0;
            end
            cslow[m] = cs[m] ? 0 : cslow[m] + 1;
         end
         cshi[m] = cs[m] ? cshi[m] + 1 : 0;
         p_sclk[m] = sclk[m];
         p_sdin[m] = sdin[m];
         p_dc[m] = dc[m];
         p_cs[m] = cs[m];
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   function automatic int get_rx(input int m, input int i);
      if (m == 0) return i < rx0.size() ? int'(rx0[i]) : -1;
      return i < rx1.size() ? int'(rx1[i]) : -1;
   endfunction

   task automatic push(input int m, input logic d, input logic [7:0] b);
      int   n = 0;
      logic r;
      if (m == 0) begin bus0.in_valid = 1'b1; bus0.in_dc = d; bus0.in_data = b; end
      else begin bus1.in_valid = 1'b1; bus1.in_dc = d; bus1.in_data = b; end
      do begin
         r = (m == 0) ? bus0.in_ready : bus1.in_ready;
         cyc();
         n++;
      end while (!r && n < 300);
      if (m == 0) bus0.in_valid = 1'b0;
      else bus1.in_valid = 1'b0;
      if (!r) chk("push_timeout", int'(r), 1);
   endtask

   task automatic wait_idle(input int m);
      int n = 0;
      while (busy[m] && n < 1000) begin
         cyc();
         n++;
      end
      chk("idle_timeout", int'(busy[m]), 0);
   endtask

   typedef struct {
      int         m;
      logic       dc;
      logic [7:0] data;
      logic [8:0] exp_word;
      int         exp_len;
   } vec_t;

   vec_t       vt[7];
   logic [8:0] w8[8];
   logic [8:0] w6[6];

   initial begin
      int r0, n0, idx, n;
      logic rdy, saw_full;
      vt[0] = '{0, 1'b0, 8'hA5, 9'b0_1010_0101, 34};
      vt[1] = '{0, 1'b1, 8'h3C, 9'b1_0011_1100, 34};
      vt[2] = '{0, 1'b0, 8'h00, 9'b0_0000_0000, 34};
      vt[3] = '{0, 1'b1, 8'hFF, 9'b1_1111_1111, 34};
      vt[4] = '{0, 1'b0, 8'h81, 9'b0_1000_0001, 34};
      vt[5] = '{1, 1'b1, 8'hA5, 9'b1_1010_0101, 17};
      vt[6] = '{1, 1'b0, 8'h5A, 9'b0_0101_1010, 17};
      w8 = '{9'h011, 9'h122, 9'h033, 9'h144, 9'h055, 9'h166, 9'h077, 9'h188};
      w6 = '{9'h1E1, 9'h0D2, 9'h1C3, 9'h0B4, 9'h1A5, 9'h096};
      bus0.in_valid = 1'b0; bus0.in_dc = 1'b0; bus0.in_data = '0;
      bus1.in_valid = 1'b0; bus1.in_dc = 1'b0; bus1.in_data = '0;

      // reset state
      rst = 1'b1;
      repeat (3) cyc();
      for (int m = 0; m < 2; m++) begin
         chk("rst_cs", int'(cs[m]), 1);
         chk("rst_sclk", int'(sclk[m]), 1);
         chk("rst_sdin", int'(sdin[m]), 0);
         chk("rst_dc", int'(dc[m]), 0);
         chk("rst_busy", int'(busy[m]), 0);
      end
      chk("rst_level0", int'(lvl0), 0);
      chk("rst_ready0", int'(bus0.in_ready), 0);
      chk("rst_ready1", int'(bus1.in_ready), 0);
      rst = 1'b0;
      cyc();
      chk("ready0_after_rst", int'(bus0.in_ready), 1);
      chk("ready1_after_rst", int'(bus1.in_ready), 1);

      // single bytes on both clock dividers
      for (int i = 0; i < 7; i++) begin
         int m;
         m = vt[i].m;
         rx0.delete();
         rx1.delete();
         r0 = rises[m];
         n0 = nlen[m];
         push(m, vt[i].dc, vt[i].data);
         wait_idle(m);
         chk($sformatf("vec%0d_count", i), m == 0 ? rx0.size() : rx1.size(), 1);
         chk($sformatf("vec%0d_word", i), get_rx(m, 0), int'(vt[i].exp_word));
         chk($sformatf("vec%0d_cs_low", i), last_len[m], vt[i].exp_len);
         chk($sformatf("vec%0d_rises", i), rises[m] - r0, 8);
         chk($sformatf("vec%0d_cs_periods", i), nlen[m] - n0, 1);
      end

      // back-to-back pair keeps CS low, DC flips in second SETUP
      rx0.delete();
      r0 = rises[0];
      n0 = nlen[0];
      push(0, 1'b0, 8'hAE);
      push(0, 1'b1, 8'h81);
      wait_idle(0);
      chk("b2b_count", rx0.size(), 2);
      chk("b2b_word0", get_rx(0, 0), 9'h0AE);
      chk("b2b_word1", get_rx(0, 1), 9'h181);
      chk("b2b_cs_low", last_len[0], 68);
      chk("b2b_rises", rises[0] - r0, 16);
      chk("b2b_cs_periods", nlen[0] - n0, 1);

      // back-to-back pair at CLK_DIV=1
      rx1.delete();
      r0 = rises[1];
      push(1, 1'b0, 8'h3C);
      push(1, 1'b1, 8'hC3);
      wait_idle(1);
      chk("div1_b2b_word0", get_rx(1, 0), 9'h03C);
      chk("div1_b2b_word1", get_rx(1, 1), 9'h1C3);
      chk("div1_b2b_cs_low", last_len[1], 34);
      chk("div1_b2b_rises", rises[1] - r0, 16);

      // eight words with in_valid held: back-pressure at level 4, order preserved
      rx0.delete();
      n0 = nlen[0];
      idx = 0;
      n = 0;
      saw_full = 1'b0;
      bus0.in_valid = 1'b1;
      {bus0.in_dc, bus0.in_data} = w8[0];
      while (idx < 8 && n < 3000) begin
         rdy = bus0.in_ready;
         if (lvl0 == 3'd4) begin
            saw_full = 1'b1;
            chk("ready_at_full", int'(rdy), 0);
         end
         cyc();
         n++;
         if (rdy) begin
            idx++;
            if (idx < 8) {bus0.in_dc, bus0.in_data} = w8[idx];
         end
      end
      bus0.in_valid = 1'b0;
      chk("stream_accepted", idx, 8);
      chk("stream_saw_full", int'(saw_full), 1);
      wait_idle(0);
      chk("stream_count", rx0.size(), 8);
      for (int i = 0; i < 8; i++) chk($sformatf("stream_word%0d", i), get_rx(0, i), int'(w8[i]));
      chk("stream_cs_low", last_len[0], 272);
      chk("stream_cs_periods", nlen[0] - n0, 1);

      // full FIFO: a pop on the same edge does not admit the waiting word
      rx0.delete();
      for (int i = 0; i < 5; i++) push(0, w6[i][8], w6[i][7:0]);
      chk("fill_level", int'(lvl0), 4);
      chk("fill_ready", int'(bus0.in_ready), 0);
      bus0.in_valid = 1'b1;
      {bus0.in_dc, bus0.in_data} = w6[5];
      n = 0;
      while (lvl0 == 3'd4 && n < 100) begin
         cyc();
         n++;
      end
      chk("full_pop_level", int'(lvl0), 3);
      chk("full_pop_ready", int'(bus0.in_ready), 1);
      cyc();
      chk("late_accept_level", int'(lvl0), 4);
      bus0.in_valid = 1'b0;
      wait_idle(0);
      chk("full_count", rx0.size(), 6);
      for (int i = 0; i < 6; i++) chk($sformatf("full_word%0d", i), get_rx(0, i), int'(w6[i]));

      // reset after the third rise aborts the byte and flushes the queue
      rx0.delete();
      push(0, 1'b1, 8'hC3);
      push(0, 1'b0, 8'h5A);
      r0 = rises[0];
      n = 0;
      while (rises[0] - r0 < 3 && n < 300) begin
         cyc();
         n++;
      end
      chk("abort_third_rise", rises[0] - r0, 3);
      rst = 1'b1;
      cyc();
      chk("abort_cs", int'(cs[0]), 1);
      chk("abort_sclk", int'(sclk[0]), 1);
      chk("abort_sdin", int'(sdin[0]), 0);
      chk("abort_dc", int'(dc[0]), 0);
      chk("abort_level", int'(lvl0), 0);
      chk("abort_ready", int'(bus0.in_ready), 0);
      chk("abort_busy", int'(busy[0]), 0);
      rst = 1'b0;
      repeat (80) cyc();
      chk("abort_no_rises", rises[0] - r0, 3);
      chk("abort_cs_idle", int'(cs[0]), 1);
      chk("abort_busy_idle", int'(busy[0]), 0);
      chk("abort_no_bytes", rx0.size(), 0);

      // transmitter still works after the abort
      push(0, 1'b1, 8'h96);
      wait_idle(0);
      chk("post_abort_word", get_rx(0, 0), 9'h196);
      chk("post_abort_cs_low", last_len[0], 34);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
